// File: rtl/morra_move_collector.sv
// -----------------------------------------------------------------------------
// morra_move_collector
//
// Front-end for MorraCinese. Each player hands over a move on its own
// valid/ready handshake, and the two moves may arrive in either order. When
// both moves are held, the pair is driven on PRIMO/SECONDO for one clock.
// On every other cycle the outputs carry NO_MOVE/NO_MOVE, which MorraCinese
// ignores. A start request produces an INIZIA cycle instead. During that
// cycle PRIMO/SECONDO carry the round-count configuration.
//
// If the second player has not arrived TIMEOUT_CYCLES cycles after the first
// move was captured, the pair is issued anyway. The missing move is filled
// and timeout_pulse is raised.
//
// Optional feature: define MORRA_RNG_FILL_EN to fill the missing move from an
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5). A fill of 00 is
// mapped to 01, so every timeout round is a valid move. When the macro is not
// defined, the missing move is 00 (NO_MOVE) and no LFSR is built.
//
// Parameters
//   TIMEOUT_CYCLES  cycles to wait for the second player (>= 2)
//   CNT_W           width of the issued-round counter
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   p1_valid       player 1 presents a move
//   p1_move        00 NO_MOVE, 01 ROCK, 10 PAPER, 11 SCISSORS
//   p1_ready       player 1 slot empty (forced low while start_req is high)
//   p2_valid       player 2 presents a move
//   p2_move        same encoding as p1_move
//   p2_ready       player 2 slot empty (forced low while start_req is high)
//   start_req      request a new game (highest priority)
//   start_cfg      [3:2] -> PRIMO, [1:0] -> SECONDO during the INIZIA cycle
//   PRIMO          registered move / config to MorraCinese
//   SECONDO        registered move / config to MorraCinese
//   INIZIA         registered restart strobe to MorraCinese
//   round_pulse    high for the one cycle a collected pair is on PRIMO/SECONDO
//   timeout_pulse  high together with round_pulse when the pair was filled
//   rounds_issued  rounds issued since the last start, saturating at all-ones
// -----------------------------------------------------------------------------
module morra_move_collector #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p1_valid,
  input  logic [1:0]       p1_move,
  output logic             p1_ready,
  input  logic             p2_valid,
  input  logic [1:0]       p2_move,
  output logic             p2_ready,
  input  logic             start_req,
  input  logic [3:0]       start_cfg,
  output logic [1:0]       PRIMO,
  output logic [1:0]       SECONDO,
  output logic             INIZIA,
  output logic             round_pulse,
  output logic             timeout_pulse,
  output logic [CNT_W-1:0] rounds_issued
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_HAS_P1 = 2'd1,
    S_HAS_P2 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot1_q, slot1_d;
  logic [1:0]       slot2_q, slot2_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       primo_q, primo_d;
  logic [1:0]       secondo_q, secondo_d;
  logic             inizia_q, inizia_d;
  logic             round_q, round_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] rounds_q, rounds_d;
  logic             issue;
  logic             p1_acc, p2_acc;
  logic [1:0]       fill_move;

  // A slot can accept a move only while it is empty. Readiness is withheld
  // during a start request, so moves offered on that edge are not taken.
  assign p1_ready = (state_q != S_HAS_P1) && !start_req;
  assign p2_ready = (state_q != S_HAS_P2) && !start_req;
  assign p1_acc   = p1_valid && p1_ready;
  assign p2_acc   = p2_valid && p2_ready;

`ifdef MORRA_RNG_FILL_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1. The register runs freely, so the
  // fill value depends on when the timeout happens.
  assign lfsr_fb   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign fill_move = (lfsr_q[1:0] == 2'b00) ? 2'b01 : lfsr_q[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= {lfsr_q[6:0], lfsr_fb};
  end
`else
  assign fill_move = 2'b00;
`endif

  // Next-state logic. The output registers default to the idle pattern
  // (00/00, no strobes). They take a pair only on the edge that completes it.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    slot1_d   = slot1_q;
    slot2_d   = slot2_q;
    timer_d   = timer_q;
    primo_d   = 2'b00;
    secondo_d = 2'b00;
    inizia_d  = 1'b0;
    round_d   = 1'b0;
    timeout_d = 1'b0;
    rounds_d  = rounds_q;
    issue     = 1'b0;

    if (start_req) begin
      state_d   = S_EMPTY;
      slot1_d   = 2'b00;
      slot2_d   = 2'b00;
      timer_d   = '0;
      primo_d   = start_cfg[3:2];
      secondo_d = start_cfg[1:0];
      inizia_d  = 1'b1;
      rounds_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (p1_acc && p2_acc) begin
            primo_d   = p1_move;
            secondo_d = p2_move;
            issue     = 1'b1;
          end else if (p1_acc) begin
            slot1_d = p1_move;
            timer_d = '0;
            state_d = S_HAS_P1;
          end else if (p2_acc) begin
            slot2_d = p2_move;
            timer_d = '0;
            state_d = S_HAS_P2;
          end
        end

        S_HAS_P1: begin
          // A move arriving on the timeout edge still completes a normal round.
          if (p2_acc) begin
            primo_d   = slot1_q;
            secondo_d = p2_move;
            issue     = 1'b1;
            slot1_d   = 2'b00;
            state_d   = S_EMPTY;
          end else if (timer_q == TIMER_LAST) begin
            primo_d   = slot1_q;
            secondo_d = fill_move;
            timeout_d = 1'b1;
            issue     = 1'b1;
            slot1_d   = 2'b00;
            state_d   = S_EMPTY;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        S_HAS_P2: begin
          if (p1_acc) begin
            primo_d   = p1_move;
            secondo_d = slot2_q;
            issue     = 1'b1;
            slot2_d   = 2'b00;
            state_d   = S_EMPTY;
          end else if (timer_q == TIMER_LAST) begin
            primo_d   = fill_move;
            secondo_d = slot2_q;
            timeout_d = 1'b1;
            issue     = 1'b1;
            slot2_d   = 2'b00;
            state_d   = S_EMPTY;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        default: begin
          state_d = S_EMPTY;
          slot1_d = 2'b00;
          slot2_d = 2'b00;
          timer_d = '0;
        end
      endcase

      if (issue) begin
        round_d  = 1'b1;
        rounds_d = (rounds_q == {CNT_W{1'b1}}) ? rounds_q : rounds_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      slot1_q   <= 2'b00;
      slot2_q   <= 2'b00;
      timer_q   <= '0;
      primo_q   <= 2'b00;
      secondo_q <= 2'b00;
      inizia_q  <= 1'b0;
      round_q   <= 1'b0;
      timeout_q <= 1'b0;
      rounds_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here keep every register sampling the
      // pre-edge values, whatever order the statements appear in.
      state_q   <= state_d;
      slot1_q   <= slot1_d;
      slot2_q   <= slot2_d;
      timer_q   <= timer_d;
      primo_q   <= primo_d;
      secondo_q <= secondo_d;
      inizia_q  <= inizia_d;
      round_q   <= round_d;
      timeout_q <= timeout_d;
      rounds_q  <= rounds_d;
    end
  end

  assign PRIMO         = primo_q;
  assign SECONDO       = secondo_q;
  assign INIZIA        = inizia_q;
  assign round_pulse   = round_q;
  assign timeout_pulse = timeout_q;
  assign rounds_issued = rounds_q;

endmodule

// File: tb/tb_morra_move_collector.sv
// -----------------------------------------------------------------------------
// tb_morra_move_collector
//
// Scoreboard bench for morra_move_collector. Each stimulus that should produce
// an output cycle pushes an expected record into a queue. The record holds the
// cycle on which the output should appear, the PRIMO/SECONDO values, the
// strobes and the rounds_issued value.
//
// A monitor runs on the falling edge. It pops and compares records whenever
// round_pulse or INIZIA is high. On idle cycles it checks that the outputs are
// 00/00 with no timeout strobe. Handshake, reset and saturation points are
// also checked directly.
// -----------------------------------------------------------------------------
module tb_morra_move_collector;

  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             p1_valid = 1'b0;
  logic [1:0]       p1_move = 2'b00;
  logic             p1_ready;
  logic             p2_valid = 1'b0;
  logic [1:0]       p2_move = 2'b00;
  logic             p2_ready;
  logic             start_req = 1'b0;
  logic [3:0]       start_cfg = 4'b0000;
  logic [1:0]       PRIMO;
  logic [1:0]       SECONDO;
  logic             INIZIA;
  logic             round_pulse;
  logic             timeout_pulse;
  logic [CNT_W-1:0] rounds_issued;

  morra_move_collector #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p1_valid     (p1_valid),
    .p1_move      (p1_move),
    .p1_ready     (p1_ready),
    .p2_valid     (p2_valid),
    .p2_move      (p2_move),
    .p2_ready     (p2_ready),
    .start_req    (start_req),
    .start_cfg    (start_cfg),
    .PRIMO        (PRIMO),
    .SECONDO      (SECONDO),
    .INIZIA       (INIZIA),
    .round_pulse  (round_pulse),
    .timeout_pulse(timeout_pulse),
    .rounds_issued(rounds_issued)
  );

  always #5 clk = ~clk;

  // fill: 0 none, 1 PRIMO was timeout-filled, 2 SECONDO was timeout-filled
  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] s;
    logic       ini;
    logic       to;
    logic [7:0] rounds;
    int         fill;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   model_rounds = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge. lat is the number of edges until the
  // output should appear.
  task automatic push(input logic [1:0] p, input logic [1:0] s, input logic ini,
                      input logic to, input int lat, input int fill);
    exp_t e;
    if (ini) model_rounds = 0;
    else     model_rounds = (model_rounds == 255) ? 255 : model_rounds + 1;
    e.cyc    = cyc + lat;
    e.p      = p;
    e.s      = s;
    e.ini    = ini;
    e.to     = to;
    e.rounds = 8'(model_rounds);
    e.fill   = fill;
    sb.push_back(e);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("event_cycle_missed", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (round_pulse || INIZIA) begin
        if (sb.size() == 0) begin
          check("unexpected_event", {30'd0, round_pulse, INIZIA}, 0);
        end else begin
          check("event_cycle", cyc, sb[0].cyc);
          if (sb[0].cyc == cyc) begin
            check("inizia", INIZIA, sb[0].ini);
            check("round_pulse", round_pulse, !sb[0].ini);
            check("timeout_pulse", timeout_pulse, sb[0].to);
            check("rounds_issued", rounds_issued, sb[0].rounds);
`ifdef MORRA_RNG_FILL_EN
            if (sb[0].fill == 1) check("primo_filled_nonzero", PRIMO != 2'b00, 1);
            else                 check("primo", PRIMO, sb[0].p);
            if (sb[0].fill == 2) check("secondo_filled_nonzero", SECONDO != 2'b00, 1);
            else                 check("secondo", SECONDO, sb[0].s);
`else
            check("primo", PRIMO, sb[0].p);
            check("secondo", SECONDO, sb[0].s);
`endif
            void'(sb.pop_front());
          end
        end
      end else begin
        check("idle_primo", PRIMO, 0);
        check("idle_secondo", SECONDO, 0);
        check("idle_timeout", timeout_pulse, 0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic [1:0] m1, m2;

    // Reset state
    #2;
    check("rst_primo", PRIMO, 0);
    check("rst_inizia", INIZIA, 0);
    check("rst_rounds", rounds_issued, 0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_p1_ready", p1_ready, 1);
    check("rst_p2_ready", p2_ready, 1);

    // Start with cfg 1001 -> INIZIA, PRIMO=10, SECONDO=01, rounds 0
    tick();
    start_req = 1'b1;
    start_cfg = 4'b1001;
    push(2'b10, 2'b01, 1'b1, 1'b0, 1, 0);
    tick();
    start_req = 1'b0;
    tick();

    // p1 PAPER, p2 ROCK three cycles later
    p1_valid = 1'b1;
    p1_move  = 2'b10;
    tick();
    p1_valid = 1'b0;
    p1_move  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("p1_ready_held_low", p1_ready, 0);
      check("p2_ready_open", p2_ready, 1);
      if (i < 2) tick();
    end
    tick();
    p2_valid = 1'b1;
    p2_move  = 2'b01;
    push(2'b10, 2'b01, 1'b0, 1'b0, 1, 0);
    tick();
    p2_valid = 1'b0;
    p2_move  = 2'b00;
    tick();
    tick();

    // p2 SCISSORS alone -> timeout, PRIMO filled
    p2_valid = 1'b1;
    p2_move  = 2'b11;
    push(2'b00, 2'b11, 1'b0, 1'b1, TIMEOUT_CYCLES + 1, 1);
    tick();
    p2_valid = 1'b0;
    p2_move  = 2'b00;
    repeat (TIMEOUT_CYCLES + 3) tick();

    // p1 ROCK alone -> timeout, SECONDO filled
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    push(2'b01, 2'b00, 1'b0, 1'b1, TIMEOUT_CYCLES + 1, 2);
    tick();
    p1_valid = 1'b0;
    p1_move  = 2'b00;
    repeat (TIMEOUT_CYCLES + 3) tick();

    // p1 SCISSORS, p2 PAPER arrives exactly on the timeout edge -> normal issue
    p1_valid = 1'b1;
    p1_move  = 2'b11;
    tick();
    p1_valid = 1'b0;
    p1_move  = 2'b00;
    repeat (TIMEOUT_CYCLES - 1) tick();
    p2_valid = 1'b1;
    p2_move  = 2'b10;
    push(2'b11, 2'b10, 1'b0, 1'b0, 1, 0);
    tick();
    p2_valid = 1'b0;
    p2_move  = 2'b00;
    tick();
    tick();

    // Both on the same edge, including an explicit pass (00)
    p1_valid = 1'b1;
    p1_move  = 2'b00;
    p2_valid = 1'b1;
    p2_move  = 2'b11;
    push(2'b00, 2'b11, 1'b0, 1'b0, 1, 0);
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    tick();
    tick();

    // Back-to-back for 300 cycles -> one pair per cycle, counter saturates
    for (int i = 0; i < 300; i++) begin
      m1 = 2'($urandom_range(0, 3));
      m2 = 2'($urandom_range(0, 3));
      p1_valid = 1'b1;
      p1_move  = m1;
      p2_valid = 1'b1;
      p2_move  = m2;
      push(m1, m2, 1'b0, 1'b0, 1, 0);
      tick();
    end
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    @(negedge clk);
    check("rounds_saturated", rounds_issued, 8'hFF);
    tick();
    start_req = 1'b1;
    start_cfg = 4'b0110;
    push(2'b01, 2'b10, 1'b1, 1'b0, 1, 0);
    tick();
    start_req = 1'b0;
    @(negedge clk);
    check("rounds_cleared_by_start", rounds_issued, 0);
    tick();

    // p1 captured, then start_req on the same edge as p2 valid
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    tick();
    p1_valid  = 1'b0;
    start_req = 1'b1;
    start_cfg = 4'b0111;
    p2_valid  = 1'b1;
    p2_move   = 2'b10;
    #1;
    check("p1_ready_start_forced", p1_ready, 0);
    check("p2_ready_start_forced", p2_ready, 0);
    push(2'b01, 2'b11, 1'b1, 1'b0, 1, 0);
    tick();
    start_req = 1'b0;
    p2_valid  = 1'b0;
    @(negedge clk);
    check("empty_after_start_p1", p1_ready, 1);
    check("empty_after_start_p2", p2_ready, 1);
    tick();

    // One round, then reset pulsed mid HAS_P1
    p1_valid = 1'b1;
    p1_move  = 2'b10;
    p2_valid = 1'b1;
    p2_move  = 2'b10;
    push(2'b10, 2'b10, 1'b0, 1'b0, 1, 0);
    tick();
    p2_valid = 1'b0;
    p1_move  = 2'b11;
    tick();
    p1_valid = 1'b0;
    @(negedge clk);
    check("has_p1_before_reset", p1_ready, 0);
    #2;
    rst_n = 1'b0;
    model_rounds = 0;
    #1;
    check("async_rst_primo", PRIMO, 0);
    check("async_rst_secondo", SECONDO, 0);
    check("async_rst_inizia", INIZIA, 0);
    check("async_rst_rounds", rounds_issued, 0);
    check("async_rst_slot_cleared", p1_ready, 1);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_p1_ready", p1_ready, 1);
    check("post_rst_p2_ready", p2_ready, 1);
    tick();

    // After reset, a fresh pair counts from 1
    p1_valid = 1'b1;
    p1_move  = 2'b01;
    p2_valid = 1'b1;
    p2_move  = 2'b11;
    push(2'b01, 2'b11, 1'b0, 1'b0, 1, 0);
    tick();
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
